// File: rtl/sim_mem_pkg.sv
// Shared constants and helpers for the simulation memory model.
package sim_mem_pkg;

  localparam int              WORD_W        = 32;
  localparam logic [WORD_W-1:0] ERR_WORD    = 32'hDEAD_BEEF;
  localparam logic [31:0]     HALT_ADDR_DEF = 32'hFFFF_FFF0;

  // Replace the strobed bytes of old_w with the matching bytes of new_w.
  function automatic logic [WORD_W-1:0] merge_bytes(
    input logic [WORD_W-1:0] old_w,
    input logic [WORD_W-1:0] new_w,
    input logic [3:0]        strb
  );
    logic [WORD_W-1:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sim_mem_rdpipe.sv
// LAT-deep valid+data delay line for one read port. Data is forced to zero
// in any stage that does not carry a valid read, so idle cycles output 0.
module sim_mem_rdpipe
  import sim_mem_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic              iClk,
  input  logic              inRst,
  input  logic              iValid,
  input  logic [WORD_W-1:0] iData,
  output logic              oValid,
  output logic [WORD_W-1:0] oData
);

  logic [LAT-1:0]             r_vld;
  logic [LAT-1:0][WORD_W-1:0] r_data;

  // Shift the request through LAT stages; reset drops everything in flight.
  always_ff @(posedge iClk or negedge inRst) begin
    if (!inRst) begin
      r_vld  <= '0;
      r_data <= '0;
    end else begin
      r_vld[0]  <= iValid;
      r_data[0] <= iValid ? iData : '0;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign oValid = r_vld[LAT-1];
  assign oData  = r_data[LAT-1];

endmodule

// File: rtl/sim_mem_pipe.sv
// Simulation memory: NRD pipelined read ports, one byte-strobed write port,
// sticky range-error flag and cycle counter. Optional halt mailbox is
// compiled in with the SIM_MEM_HALT_EN macro.
module sim_mem_pipe
  import sim_mem_pkg::*;
#(
  parameter int          NRD       = 2,
  parameter int          AW        = 14,
  parameter int          LAT       = 1,
  parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEF
) (
  input  logic                  iClk,
  input  logic                  inRst,
  input  logic [NRD-1:0]        iRdEn,
  input  logic [NRD*WORD_W-1:0] iRdAddr,
  output logic [NRD-1:0]        oRdValid,
  output logic [NRD*WORD_W-1:0] oRdData,
  input  logic                  iWrEn,
  input  logic [31:0]           iWrAddr,
  input  logic [WORD_W-1:0]     iWrData,
  input  logic [3:0]            iWstrb,
  output logic [WORD_W-1:0]     oLastData,
  output logic                  oErr,
  output logic                  oHalt,
  output logic [31:0]           oExitCode,
  output logic [31:0]           oCycles
);

  localparam int DEPTH = 1 << AW;

  logic [WORD_W-1:0]     r_mem [DEPTH];
  logic [WORD_W-1:0]     r_last;
  logic                  r_err;
  logic [31:0]           r_cycles;

  logic [NRD-1:0]        w_rd_oor;
  logic [NRD*WORD_W-1:0] w_rd_word;
  logic [NRD*2-1:0]      w_rd_lsb;
  logic [AW-1:0]         w_wr_idx;
  logic                  w_wr_oor;
  logic                  w_wr_halt;
  logic                  w_halt_hit;
  logic                  w_halt;
  logic                  w_wr_do;
  logic [WORD_W-1:0]     w_wr_merged;
  logic                  w_err_set;
  logic                  w_unused_bits;

  // Read ports: array is read combinationally at the sampling edge, so a
  // same-cycle write is not yet visible (read-before-write).
  for (genvar gp = 0; gp < NRD; gp++) begin : g_rd
    logic [31:0] w_addr;
    assign w_addr                   = iRdAddr[WORD_W*gp +: WORD_W];
    assign w_rd_oor[gp]             = |w_addr[31:AW+2];
    assign w_rd_lsb[2*gp +: 2]      = w_addr[1:0];
    assign w_rd_word[WORD_W*gp +: WORD_W] =
      w_rd_oor[gp] ? ERR_WORD : r_mem[w_addr[AW+1:2]];

    sim_mem_rdpipe #(.LAT(LAT)) u_rdpipe (
      .iClk   (iClk),
      .inRst  (inRst),
      .iValid (iRdEn[gp]),
      .iData  (w_rd_word[WORD_W*gp +: WORD_W]),
      .oValid (oRdValid[gp]),
      .oData  (oRdData[WORD_W*gp +: WORD_W])
    );
  end

  assign w_wr_idx    = iWrAddr[AW+1:2];
  assign w_wr_oor    = |iWrAddr[31:AW+2];
  assign w_wr_halt   = (iWrAddr == HALT_ADDR);
  assign w_wr_do     = iWrEn && !w_wr_oor && !w_halt_hit && (iWstrb != 4'b0000);
  assign w_wr_merged = merge_bytes(r_mem[w_wr_idx], iWrData, iWstrb);
  assign w_err_set   = (|(iRdEn & w_rd_oor)) || (iWrEn && w_wr_oor && !w_halt_hit);
  assign w_unused_bits = ^{w_rd_lsb, iWrAddr[1:0]};

  // Memory array: written only, never reset.
  always_ff @(posedge iClk) begin
    if (w_wr_do) r_mem[w_wr_idx] <= w_wr_merged;
  end

  // Last stored word and sticky error flag.
  always_ff @(posedge iClk or negedge inRst) begin
    if (!inRst) begin
      r_last <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_wr_do)   r_last <= w_wr_merged;
      if (w_err_set) r_err  <= 1'b1;
    end
  end

  // Saturating cycle counter, frozen once halted.
  always_ff @(posedge iClk or negedge inRst) begin
    if (!inRst)                                r_cycles <= '0;
    else if (!w_halt && (r_cycles != '1))      r_cycles <= r_cycles + 32'd1;
  end

`ifdef SIM_MEM_HALT_EN
  logic        r_halt;
  logic [31:0] r_exit;

  assign w_halt_hit = w_wr_halt;

  // First halt-mailbox write with any strobe set wins; later ones ignored.
  always_ff @(posedge iClk or negedge inRst) begin
    if (!inRst) begin
      r_halt <= 1'b0;
      r_exit <= '0;
    end else if (iWrEn && w_wr_halt && (iWstrb != 4'b0000) && !r_halt) begin
      r_halt <= 1'b1;
      r_exit <= iWrData;
    end
  end

  assign w_halt    = r_halt;
  assign oHalt     = r_halt;
  assign oExitCode = r_exit;
`else
  logic w_unused_halt;
  assign w_unused_halt = w_wr_halt;
  assign w_halt_hit    = 1'b0;
  assign w_halt        = 1'b0;
  assign oHalt         = 1'b0;
  assign oExitCode     = '0;
`endif

  assign oLastData = r_last;
  assign oErr      = r_err;
  assign oCycles   = r_cycles;

endmodule

// File: doc/sim_mem_pipe.md
SIM_MEM_PIPE -- requirements
Module: sim_mem_pipe

Interface
REQ-001 SHALL have parameter NRD, default 2, number of independent read ports (1..4).
REQ-002 SHALL have parameter AW, default 14, word-address width (memory holds 2^AW 32-bit words).
REQ-003 SHALL have parameter LAT, default 1, read latency in cycles (1..4).
REQ-004 SHALL have parameter HALT_ADDR, default 32'hFFFF_FFF0, byte address of the halt mailbox.
REQ-005 SHALL have port iClk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port inRst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port iRdEn  input  NRD  per-port read request.
REQ-008 SHALL have port iRdAddr  input  NRD*32  per-port byte address; port p in bits [32p+31:32p].
REQ-009 SHALL have port oRdValid  output  NRD  per-port read-data valid.
REQ-010 SHALL have port oRdData  output  NRD*32  per-port read data; same packing as iRdAddr.
REQ-011 SHALL have port iWrEn / iWrAddr / iWrData / iWstrb  input  1/32/32/4  write request, byte address, data, byte strobes.
REQ-012 SHALL have port oLastData  output  32  merged word most recently stored by a write.
REQ-013 SHALL have ports oErr  output  1  sticky out-of-range flag; oHalt  output  1  sticky halt; oExitCode  output  32; oCycles  output  32  cycle count.

Function
REQ-014 Word index SHALL be addr[AW+1:2]; addr[1:0] ignored; addr[31:AW+2] nonzero = out of range.
REQ-015 Read sampled when iRdEn[p]=1 SHALL produce oRdValid[p]=1 with data exactly LAT cycles later, one result per request, fully pipelined (one request per port per cycle).
REQ-016 oRdValid[p] SHALL be 0 in every cycle without a matching request LAT cycles earlier; oRdData[p] SHALL then be 0.
REQ-017 Out-of-range read SHALL return 32'hDEAD_BEEF and set oErr.
REQ-018 Write with iWrEn=1 SHALL update only bytes with iWstrb[i]=1; iWstrb=0 writes nothing and leaves oLastData unchanged.
REQ-019 Read and write to same word in same cycle SHALL return pre-write data (read-before-write); all ports reading one word SHALL get identical data.
REQ-020 oLastData SHALL equal the full merged word (old bytes plus strobed new bytes) the cycle after the write.
REQ-021 Out-of-range write SHALL be dropped and set oErr, except at HALT_ADDR when halt is compiled in.
REQ-022 oCycles SHALL increment every cycle after reset release, saturate at 32'hFFFF_FFFF, and freeze once oHalt=1.
REQ-023 After oHalt=1, reads and writes SHALL continue to operate normally.

Reset
REQ-024 Reset SHALL clear oRdValid, oRdData, oLastData, oErr, oHalt, oExitCode, oCycles to 0 asynchronously.
REQ-025 Reads in flight at reset SHALL be discarded; no oRdValid for them after release.
REQ-026 Memory array contents SHALL NOT be reset.

Configuration
REQ-027 With SIM_MEM_HALT_EN defined, a write to HALT_ADDR with nonzero iWstrb SHALL set oHalt and load oExitCode with iWrData the next cycle; the first halt write wins, later ones ignored; array untouched.
REQ-028 Without SIM_MEM_HALT_EN, oHalt and oExitCode SHALL be tied 0 and HALT_ADDR treated as ordinary (out-of-range) address.

Structure
REQ-029 Package sim_mem_pkg SHALL hold the 32-bit word width, the 32'hDEAD_BEEF error pattern and the default HALT_ADDR.
REQ-030 Sub-module sim_mem_rdpipe SHALL implement one LAT-deep valid+data delay line, instantiated NRD times.

Verification
REQ-031 LAT=3: write 0x1234_5678 to 0x100, read port 1 at 0x100 -> oRdValid[1] exactly 3 cycles later, data 0x1234_5678.
REQ-032 Word 0x200=0xAABB_CCDD; write 0x1122_3344 strobe 4'b0101 -> oLastData 0xAA22_CC44; later read same.
REQ-033 Same-cycle write 0x0 and read at 0x300 holding 0x5555_5555 -> read returns 0x5555_5555; next read 0x0.
REQ-034 AW=14, read 0x0001_0000 -> data 0xDEAD_BEEF, oErr=1 and stays 1.
REQ-035 SIM_MEM_HALT_EN, write 0x2A to 0xFFFF_FFF0 then 0x7 -> oHalt=1, oExitCode=0x2A, oCycles frozen.
REQ-036 Assert inRst with reads in flight -> all outputs 0 immediately, no stale oRdValid after release.
